// File: rtl/harness_ctrl_pkg.sv
// Shared types for the harness run controller: FSM states, verdict codes and
// the width of the failing-source index.
package harness_ctrl_pkg;

  localparam int unsigned FAIL_SRC_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FAIL_NONE    = 2'd0,
    FAIL_SRC     = 2'd1,
    FAIL_TIMEOUT = 2'd2
  } fail_code_e;

endpackage

// File: rtl/harness_src_tracker.sv
// Per-source sticky success bits, enable masking, all-success reduce and a
// lowest-index priority encoder over the masked failure vector.
module harness_src_tracker
  import harness_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  update,
  input  logic [NUM_SRC-1:0]    enable,
  input  logic [NUM_SRC-1:0]    src_success,
  input  logic [NUM_SRC-1:0]    src_fail,
  output logic                  all_ok_c,
  output logic                  any_fail_c,
  output logic [FAIL_SRC_W-1:0] fail_idx_c
);

  logic [NUM_SRC-1:0] ok_q;
  logic [NUM_SRC-1:0] ok_now;
  logic [NUM_SRC-1:0] fail_vec;

  // A success arriving this cycle counts toward the verdict immediately.
  assign ok_now     = ok_q | (src_success & enable);
  assign fail_vec   = src_fail & enable;
  assign all_ok_c   = (enable != '0) && ((ok_now & enable) == enable);
  assign any_fail_c = |fail_vec;

  always_comb begin
    fail_idx_c = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (fail_vec[i]) fail_idx_c = FAIL_SRC_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ok_q <= '0;
    end else if (clear) begin
      ok_q <= '0;
    end else if (update) begin
      ok_q <= ok_now;
    end
  end

endmodule

// File: rtl/harness_run_controller.sv
// Run sequencer: holds DUT reset, counts run cycles, collects source verdicts
// with a cycle-limit timeout, then drains before raising a sticky done.
module harness_run_controller
  import harness_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned CYCLE_W      = 64,
  parameter int unsigned RESET_HOLD   = 16,
  parameter int unsigned DRAIN_CYCLES = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CYCLE_W-1:0]    max_cycles,
  input  logic [NUM_SRC-1:0]    src_enable,
  input  logic [NUM_SRC-1:0]    src_success,
  input  logic [NUM_SRC-1:0]    src_fail,
  output logic                  dut_reset,
  output logic                  running,
  output logic [CYCLE_W-1:0]    cycle_count,
  output logic                  done,
  output logic                  pass,
  output logic [1:0]            fail_code,
  output logic [FAIL_SRC_W-1:0] fail_src
);

  localparam int unsigned TMR_MAX = (RESET_HOLD > DRAIN_CYCLES) ? RESET_HOLD : DRAIN_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(RESET_HOLD - 1);
  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_CYCLES - 1);

  state_e                state_q, state_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [CYCLE_W-1:0]    max_q, max_d;
  logic [NUM_SRC-1:0]    enable_q, enable_d;
  logic [CYCLE_W-1:0]    count_d;
  logic                  dut_reset_d, running_d, done_d, pass_d;
  fail_code_e            code_q, code_d;
  logic [FAIL_SRC_W-1:0] fail_src_d;

  logic                  clear_c, update_c, timeout_c;
  logic                  all_ok_c, any_fail_c;
  logic [FAIL_SRC_W-1:0] fail_idx_c;

  assign update_c  = (state_q == RUN);
  assign timeout_c = (max_q != '0) && (cycle_count >= max_q);
  assign fail_code = code_q;

  harness_src_tracker #(
    .NUM_SRC(NUM_SRC)
  ) u_tracker (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear_c),
    .update     (update_c),
    .enable     (enable_q),
    .src_success(src_success),
    .src_fail   (src_fail),
    .all_ok_c   (all_ok_c),
    .any_fail_c (any_fail_c),
    .fail_idx_c (fail_idx_c)
  );

  // Next-state, counters and verdict; output registers follow the next state.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    max_d       = max_q;
    enable_d    = enable_q;
    count_d     = cycle_count;
    pass_d      = pass;
    code_d      = code_q;
    fail_src_d  = fail_src;
    clear_c     = 1'b0;
    dut_reset_d = 1'b1;
    running_d   = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = HOLD;
          tmr_d      = HOLD_LOAD;
          max_d      = max_cycles;
          enable_d   = src_enable;
          count_d    = '0;
          pass_d     = 1'b0;
          code_d     = FAIL_NONE;
          fail_src_d = '0;
          clear_c    = 1'b1;
        end
      end
      HOLD: begin
        if (tmr_q == '0) begin
          state_d = RUN;
          count_d = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      RUN: begin
        if (cycle_count != '1) count_d = cycle_count + CYCLE_W'(1);
        // Same-cycle priority: fail, then timeout, then success.
        if (any_fail_c) begin
          state_d    = DRAIN;
          tmr_d      = DRAIN_LOAD;
          pass_d     = 1'b0;
          code_d     = FAIL_SRC;
          fail_src_d = fail_idx_c;
        end else if (timeout_c) begin
          state_d    = DRAIN;
          tmr_d      = DRAIN_LOAD;
          pass_d     = 1'b0;
          code_d     = FAIL_TIMEOUT;
          fail_src_d = '0;
        end else if (all_ok_c) begin
          state_d    = DRAIN;
          tmr_d      = DRAIN_LOAD;
          pass_d     = 1'b1;
          code_d     = FAIL_NONE;
          fail_src_d = '0;
        end
      end
      DRAIN: begin
        if (tmr_q == '0) begin
          state_d = DONE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    dut_reset_d = !((state_d == RUN) || (state_d == DRAIN));
    running_d   = (state_d == RUN);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      max_q       <= '0;
      enable_q    <= '0;
      cycle_count <= '0;
      dut_reset   <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      code_q      <= FAIL_NONE;
      fail_src    <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      max_q       <= max_d;
      enable_q    <= enable_d;
      cycle_count <= count_d;
      dut_reset   <= dut_reset_d;
      running     <= running_d;
      done        <= done_d;
      pass        <= pass_d;
      code_q      <= code_d;
      fail_src    <= fail_src_d;
    end
  end

endmodule

// File: tb/tb_harness_run_controller.sv
// Self-checking bench: per-run verdict model plus a timeline model checked on
// every cycle, with directed cases, a mid-run reset and a narrow-counter build.
module tb_harness_run_controller;

  localparam int RH   = 16;
  localparam int DR   = 8;
  localparam int MAXK = 128;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [63:0] max_cycles;
  logic [3:0]  src_enable, src_success, src_fail;
  logic        dut_reset, running, done, pass;
  logic [63:0] cycle_count;
  logic [1:0]  fail_code;
  logic [3:0]  fail_src;

  logic        sm_reset, sm_start;
  logic [3:0]  sm_max, sm_en, sm_succ, sm_fail;
  logic        sm_dut_reset, sm_running, sm_done, sm_pass;
  logic [3:0]  sm_count;
  logic [1:0]  sm_code;
  logic [3:0]  sm_src;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  succ_a [MAXK];
  logic [3:0]  fail_a [MAXK];
  int          m_v;
  logic        m_pass;
  logic [1:0]  m_code;
  logic [3:0]  m_src;
  logic        m_active = 1'b0;
  int          m_c;
  logic [63:0] last_run_count;
  int          first_done;

  always #5 clock = ~clock;

  harness_run_controller #(
    .NUM_SRC(4), .CYCLE_W(64), .RESET_HOLD(RH), .DRAIN_CYCLES(DR)
  ) u_dut (
    .clock(clock), .reset(reset), .start(start), .max_cycles(max_cycles),
    .src_enable(src_enable), .src_success(src_success), .src_fail(src_fail),
    .dut_reset(dut_reset), .running(running), .cycle_count(cycle_count),
    .done(done), .pass(pass), .fail_code(fail_code), .fail_src(fail_src)
  );

  harness_run_controller #(
    .NUM_SRC(4), .CYCLE_W(4), .RESET_HOLD(2), .DRAIN_CYCLES(2)
  ) u_small (
    .clock(clock), .reset(sm_reset), .start(sm_start), .max_cycles(sm_max),
    .src_enable(sm_en), .src_success(sm_succ), .src_fail(sm_fail),
    .dut_reset(sm_dut_reset), .running(sm_running), .cycle_count(sm_count),
    .done(sm_done), .pass(sm_pass), .fail_code(sm_code), .fail_src(sm_src)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Verdict of one run from the source rules; k is the RUN-cycle index.
  task automatic model(input logic [3:0] en, input logic [63:0] mx, output int v,
                       output logic p, output logic [1:0] code, output logic [3:0] src);
    logic [3:0] ok;
    logic [3:0] fv;
    ok = 4'b0; v = -1; p = 1'b0; code = 2'd0; src = 4'd0;
    for (int k = 0; k < MAXK && v < 0; k++) begin
      fv = fail_a[k] & en;
      ok = ok | (succ_a[k] & en);
      if (fv != 4'b0) begin
        v = k; code = 2'd1;
        for (int i = 3; i >= 0; i--) if (fv[i]) src = 4'(i);
      end else if (mx != 64'd0 && 64'(k) >= mx) begin
        v = k; code = 2'd2;
      end else if (en != 4'b0 && ok == en) begin
        v = k; p = 1'b1;
      end
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k < MAXK; k++) begin
      succ_a[k] = 4'b0;
      fail_a[k] = 4'b0;
    end
  endtask

  task automatic do_run(input logic [3:0] en, input logic [63:0] mx, input bit poke);
    int total;
    int k;
    model(en, mx, m_v, m_pass, m_code, m_src);
    if (m_v < 0) begin
      n_tests++; n_fail++;
      $display("FAIL model_verdict: none within %0d run cycles", MAXK);
      return;
    end
    last_run_count = '1;
    first_done = -1;
    @(negedge clock);
    start = 1'b1; max_cycles = mx; src_enable = en; src_success = 4'b0; src_fail = 4'b0;
    m_c = 0; m_active = 1'b1;
    total = RH + m_v + 1 + DR + 3;
    for (int j = 0; j < total; j++) begin
      @(negedge clock);
      start = 1'b0; src_success = 4'b0; src_fail = 4'b0;
      k = j - RH;
      if (k >= 0 && k < MAXK) begin
        src_success = succ_a[k];
        src_fail    = fail_a[k];
      end
      // Starts during HOLD/RUN/DRAIN must be ignored, along with their bus values.
      if (j <= RH + m_v + DR && ((poke && (j == 3 || j == RH + m_v + 2)) ||
                                 $urandom_range(0, 11) == 0)) begin
        start = 1'b1;
        max_cycles = 64'($urandom_range(1, 5));
        src_enable = 4'($urandom);
      end
    end
    @(negedge clock);
    m_active = 1'b0; start = 1'b0; src_success = 4'b0; src_fail = 4'b0;
  endtask

  // Timeline check: HOLD for RH cycles, RUN through the verdict cycle, DRAIN for DR, then DONE.
  initial begin
    int c;
    logic e_dr, e_run, e_done, e_pass;
    logic [63:0] e_cnt;
    logic [1:0] e_code;
    logic [3:0] e_src;
    forever begin
      @(posedge clock);
      #1;
      if (m_active) begin
        c = m_c;
        e_pass = 1'b0; e_code = 2'd0; e_src = 4'd0; e_done = 1'b0;
        if (c < RH) begin
          e_dr = 1'b1; e_run = 1'b0; e_cnt = 64'd0;
        end else if (c <= RH + m_v) begin
          e_dr = 1'b0; e_run = 1'b1; e_cnt = 64'(c - RH);
        end else begin
          e_run = 1'b0; e_cnt = 64'(m_v + 1);
          e_pass = m_pass; e_code = m_code; e_src = m_src;
          e_done = (c >= RH + m_v + 1 + DR);
          e_dr = e_done;
        end
        chk("cyc_dut_reset", dut_reset, e_dr);
        chk("cyc_running", running, e_run);
        chk("cyc_cycle_count", cycle_count, e_cnt);
        chk("cyc_done", done, e_done);
        chk("cyc_pass", pass, e_pass);
        chk("cyc_fail_code", fail_code, e_code);
        chk("cyc_fail_src", fail_src, e_src);
        if (running) last_run_count = cycle_count;
        if (done && first_done < 0) first_done = c;
        m_c++;
      end
    end
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_dut_reset"}, dut_reset, 1);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fail_code"}, fail_code, 0);
    chk({tag, "_fail_src"}, fail_src, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; max_cycles = 64'd0; src_enable = 4'b0;
    src_success = 4'b0; src_fail = 4'b0;
    sm_reset = 1'b1; sm_start = 1'b0; sm_max = 4'd0; sm_en = 4'b0;
    sm_succ = 4'b0; sm_fail = 4'b0;
    clear_stim();
    repeat (3) @(posedge clock);
    #1;
    chk_reset_values("rst");
    @(negedge clock);
    reset = 1'b0; sm_reset = 1'b0;
    @(posedge clock);
    #1;
    chk_reset_values("idle");

    // Normal pass with stray starts in HOLD and DRAIN.
    clear_stim(); succ_a[5] = 4'b0001; succ_a[9] = 4'b0010;
    do_run(4'b0011, 64'd0, 1'b1);
    chk("pass_model_v", m_v, 9);
    chk("pass_last_run_count", last_run_count, 9);
    chk("pass_cycle_count", cycle_count, 10);
    chk("pass_pass", pass, 1);
    chk("pass_code", fail_code, 0);
    chk("pass_done_at", first_done, 34);

    // Fail beats a simultaneous all-ones success.
    clear_stim(); fail_a[3] = 4'b1010; succ_a[3] = 4'b1111;
    do_run(4'b1111, 64'd0, 1'b0);
    chk("srcfail_model_v", m_v, 3);
    chk("srcfail_pass", pass, 0);
    chk("srcfail_code", fail_code, 1);
    chk("srcfail_src", fail_src, 1);

    clear_stim();
    do_run(4'b0001, 64'd20, 1'b0);
    chk("timeout_code", fail_code, 2);
    chk("timeout_verdict_count", last_run_count, 20);
    chk("timeout_cycle_count", cycle_count, 21);

    clear_stim(); fail_a[20] = 4'b0001;
    do_run(4'b0001, 64'd20, 1'b0);
    chk("tofail_code", fail_code, 1);
    chk("tofail_src", fail_src, 0);

    // Masked fail is ignored; run ends on the enabled source's success.
    clear_stim(); fail_a[2] = 4'b0001; succ_a[6] = 4'b0100;
    do_run(4'b0100, 64'd0, 1'b0);
    chk("masked_model_v", m_v, 6);
    chk("masked_pass", pass, 1);

    clear_stim();
    for (int k = 0; k < MAXK; k += 4) succ_a[k] = 4'b1111;
    do_run(4'b0000, 64'd50, 1'b0);
    chk("empty_code", fail_code, 2);
    chk("empty_verdict_count", last_run_count, 50);

    // Reset at RUN cycle 7 wins over a simultaneous start.
    clear_stim(); succ_a[2] = 4'b0001;
    @(negedge clock);
    start = 1'b1; max_cycles = 64'd0; src_enable = 4'b0011;
    m_v = 1000; m_pass = 1'b0; m_code = 2'd0; m_src = 4'd0; m_c = 0; m_active = 1'b1;
    for (int j = 0; j < RH + 7; j++) begin
      @(negedge clock);
      start = 1'b0;
      src_success = (j >= RH) ? succ_a[j - RH] : 4'b0;
    end
    @(negedge clock);
    m_active = 1'b0; reset = 1'b1; start = 1'b1; src_success = 4'b0;
    @(posedge clock);
    #1;
    chk_reset_values("midrst");
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    @(posedge clock);
    #1;
    chk_reset_values("midrst_idle");
    clear_stim(); succ_a[3] = 4'b0010;
    do_run(4'b0011, 64'd30, 1'b0);
    chk("postrst_code", fail_code, 2);

    // Narrow counter saturates instead of wrapping.
    @(negedge clock);
    sm_start = 1'b1; sm_max = 4'd0; sm_en = 4'b0;
    @(negedge clock);
    sm_start = 1'b0;
    repeat (16) @(posedge clock);
    #1;
    chk("sat_count_14", sm_count, 14);
    @(posedge clock);
    #1;
    chk("sat_count_15", sm_count, 15);
    repeat (5) @(posedge clock);
    #1;
    chk("sat_count_hold", sm_count, 15);
    chk("sat_running", sm_running, 1);
    @(negedge clock);
    sm_reset = 1'b1;

    repeat (25) begin
      for (int k = 0; k < MAXK; k++) begin
        succ_a[k] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
        fail_a[k] = ($urandom_range(0, 30) == 0) ? 4'($urandom) : 4'b0;
      end
      do_run(4'($urandom), 64'($urandom_range(1, 60)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/harness_run_controller.md
Name: harness_run_controller

Overview:
Synthesizable run sequencer for the simulation test harness. It sequences DUT reset release, counts run cycles, gathers pass/fail indications from several harness sources, and applies a cycle-limit timeout. It produces one final, latched verdict that the top-level testbench or UVM layer samples to end simulation. It sits between the testbench clock/reset generator and TestHarness, replacing ad-hoc end-of-test logic in the driver.

Parameters:
NUM_SRC, 4, number of success/fail reporting sources (1..16)
CYCLE_W, 64, width of the cycle counter and cycle limit
RESET_HOLD, 16, cycles the DUT reset is held after start (>=1)
DRAIN_CYCLES, 8, cycles between verdict and done, allowing trace/VCD flush (>=1)

Ports:
clock  in  1  harness clock
reset  in  1  synchronous, active-high controller reset
start  in  1  single-cycle pulse that begins a run
max_cycles  in  CYCLE_W  timeout limit; 0 = no timeout; sampled on start
src_enable  in  NUM_SRC  mask of sources that take part; sampled on start
src_success  in  NUM_SRC  per-source success pulse/level
src_fail  in  NUM_SRC  per-source failure pulse/level
dut_reset  out  1  reset to TestHarness
running  out  1  high in RUN state
cycle_count  out  CYCLE_W  cycles elapsed in RUN, saturating
done  out  1  verdict final; sticky
pass  out  1  valid when done
fail_code  out  2  0 none, 1 source fail, 2 timeout
fail_src  out  4  lowest failing source index; valid when fail_code==1

Behaviour:
- Reset (sync, active-high) values: state IDLE, dut_reset=1, running=0, cycle_count=0, done=0, pass=0, fail_code=0, fail_src=0. All sticky bits are cleared. Reset wins over every other event, including mid-run.
- States: IDLE, HOLD, RUN, DRAIN, DONE.
- IDLE:
  - dut_reset=1.
  - start -> HOLD. The hold counter is loaded with RESET_HOLD-1, and max_cycles and src_enable are latched.
- HOLD:
  - dut_reset=1.
  - The counter decrements each cycle.
  - When the counter is 0 -> RUN and cycle_count clears to 0.
  - dut_reset is 1 for exactly RESET_HOLD cycles after the start edge.
- RUN:
  - dut_reset=0, running=1.
  - cycle_count increments by 1 each cycle and saturates at all-ones (no wrap).
  - src_success[i] sets sticky ok[i] only when enable[i] is set.
  - Success condition: enable!=0 and (ok|new success)&enable == enable. An all-zero enable mask never succeeds; only a fail or timeout can end the run.
  - Fail condition: |(src_fail & enable). fail_src = lowest set index of that vector.
  - Timeout condition: latched max_cycles!=0 and cycle_count+1 > max_cycles. The verdict is raised in the cycle where cycle_count equals max_cycles.
  - Same-cycle priority: fail > timeout > success.
  - On a verdict: latch pass, fail_code and fail_src; go to DRAIN with the drain counter loaded with DRAIN_CYCLES-1; cycle_count freezes.
- DRAIN:
  - dut_reset=0.
  - Source inputs are ignored and the verdict is frozen.
  - When the counter is 0 -> DONE.
- DONE:
  - done=1, dut_reset=1.
  - Outputs are held.
  - start -> HOLD and clears done, pass, fail_code, fail_src, sticky ok bits and cycle_count. The new run latches fresh max_cycles and src_enable.
- start is ignored in HOLD, RUN and DRAIN.
- src_success and src_fail are treated as levels sampled every RUN cycle. A pulse of one cycle is sufficient.
- Latency from a fail pulse in cycle N: fail_code is valid at N+1, and done rises at N+1+DRAIN_CYCLES.

Decomposition:
- Shared package harness_ctrl_pkg holds:
  - the state enum (IDLE, HOLD, RUN, DRAIN, DONE);
  - the fail_code enum (FAIL_NONE=0, FAIL_SRC=1, FAIL_TIMEOUT=2);
  - the FAIL_SRC_W=4 constant.
- One sub-module, harness_src_tracker, holds the per-source sticky ok bits, the enable masking, the all-success reduce and the lowest-index fail priority encoder. It is purely local to this block.
- The FSM, counters and verdict latch stay in the top module.

Test Plan:
- Normal pass:
  - Stimulus: enable=4'b0011, max=0, start; src_success[0] at RUN cycle 5 and [1] at RUN cycle 9.
  - Required: dut_reset low exactly 16 cycles after start; pass=1, fail_code=0, cycle_count=10; done 8 cycles after the verdict.
- Source fail priority:
  - Stimulus: enable=4'b1111; src_fail=4'b1010 at RUN cycle 3, with src_success all-ones in the same cycle.
  - Required: pass=0, fail_code=1, fail_src=1.
- Timeout:
  - Stimulus: max_cycles=20, enable=4'b0001, no success.
  - Required: verdict when cycle_count=20; fail_code=2. A fail pulse in the same cycle instead gives fail_code=1.
- Masked source and empty mask:
  - Stimulus: enable=4'b0100 with src_fail[0] pulsed.
  - Required: no verdict from that pulse.
  - Stimulus: enable=0, max=50.
  - Required: timeout at cycle 50; success pulses are ignored.
- Reset mid-run:
  - Stimulus: assert reset at RUN cycle 7.
  - Required: next cycle IDLE with all outputs at reset values; start in HOLD and DRAIN has no effect.
- Restart and saturation:
  - Stimulus: start from DONE.
  - Required: status clears and a new run latches new max_cycles.
  - Stimulus: CYCLE_W=4 build, max=0, run 20 cycles.
  - Required: cycle_count holds at 15.
